// File: rtl/exe_stage_md_if.sv
// Decode-to-execute pipeline channel: valid/allowin handshake plus the decoded instruction fields.
interface exe_stage_md_if #(
   parameter int XLEN = 32
);
   logic            ds_to_es_valid;
   logic            es_allowin;
   logic [11:0]     ds_alu_op;
   logic [2:0]      ds_md_op;
   logic [XLEN-1:0] ds_src1;
   logic [XLEN-1:0] ds_src2;
   logic [XLEN-1:0] ds_st_data;
   logic            ds_mem_re;
   logic            ds_mem_we;
   logic [1:0]      ds_mem_size;
   logic            ds_mem_unsigned;
   logic            ds_gr_we;
   logic [4:0]      ds_dest;
   logic [XLEN-1:0] ds_pc;

   modport master (
      output ds_to_es_valid, ds_alu_op, ds_md_op, ds_src1, ds_src2, ds_st_data,
             ds_mem_re, ds_mem_we, ds_mem_size, ds_mem_unsigned, ds_gr_we, ds_dest, ds_pc,
      input  es_allowin
   );

   modport slave (
      input  ds_to_es_valid, ds_alu_op, ds_md_op, ds_src1, ds_src2, ds_st_data,
             ds_mem_re, ds_mem_we, ds_mem_size, ds_mem_unsigned, ds_gr_we, ds_dest, ds_pc,
      output es_allowin
   );
endinterface

// File: rtl/exe_stage_md.sv
// Execute stage: one-hot ALU, single-cycle multiply, iterative restoring divide,
// and byte/half/word/dword data-SRAM request generation with misalignment detection.
module exe_stage_md #(
   parameter int XLEN  = 32,
   parameter int NBYTE = XLEN / 8,
   parameter int OFFW  = $clog2(NBYTE)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             ms_allowin,
   exe_stage_md_if.slave    ds,
   output logic             es_to_ms_valid,
   output logic [XLEN-1:0]  es_result,
   output logic             es_gr_we,
   output logic             es_mem_re,
   output logic             es_mem_unsigned,
   output logic [1:0]       es_mem_size,
   output logic [4:0]       es_dest,
   output logic [XLEN-1:0]  es_pc,
   output logic             es_ale,
   output logic             es_fwd_valid,
   output logic             es_fwd_blk,
   output logic [4:0]       es_fwd_dest,
   output logic [XLEN-1:0]  es_fwd_data,
   output logic             data_sram_en,
   output logic [NBYTE-1:0] data_sram_wen,
   output logic [XLEN-1:0]  data_sram_addr,
   output logic [XLEN-1:0]  data_sram_wdata
);

   localparam int SHW  = $clog2(XLEN);
   localparam int CNTW = $clog2(XLEN);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic neg);
      return neg ? (~v + XLEN'(1)) : v;
   endfunction

   logic            vld_p0;
   logic [11:0]     alu_op_p0;
   logic [2:0]      md_op_p0;
   logic [XLEN-1:0] src1_p0, src2_p0, st_data_p0, pc_p0;
   logic            mem_re_p0, mem_we_p0, mem_unsigned_p0, gr_we_p0;
   logic [1:0]      mem_size_p0;
   logic [4:0]      dest_p0;

   logic            es_ready_go;
   logic            capture;
   logic            div_class;
   logic            div_signed;

   logic [1:0]      div_state;
   logic [CNTW-1:0] div_cnt;
   logic [XLEN-1:0] q_acc, r_acc, d_mag;
   logic            q_neg, r_neg, div_zero;

   assign div_class  = md_op_p0[2];
   assign div_signed = div_class && !md_op_p0[1];
   assign es_ready_go = !(div_class && (div_state != DONE));
   assign ds.es_allowin = !vld_p0 || (es_ready_go && ms_allowin);
   assign capture    = ds.ds_to_es_valid && ds.es_allowin && !flush;
   assign es_to_ms_valid = vld_p0 && es_ready_go && !flush;

   // ---- stage p0: decode -> execute capture ----
   always_ff @(posedge clk) begin
      if (reset) begin
         vld_p0 <= 1'b0;
      end else if (flush) begin
         vld_p0 <= 1'b0;
      end else if (ds.es_allowin) begin
         vld_p0 <= ds.ds_to_es_valid;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         alu_op_p0       <= '0;
         md_op_p0        <= '0;
         src1_p0         <= '0;
         src2_p0         <= '0;
         st_data_p0      <= '0;
         pc_p0           <= '0;
         mem_re_p0       <= 1'b0;
         mem_we_p0       <= 1'b0;
         mem_unsigned_p0 <= 1'b0;
         gr_we_p0        <= 1'b0;
         mem_size_p0     <= '0;
         dest_p0         <= '0;
      end else if (capture) begin
         alu_op_p0       <= ds.ds_alu_op;
         md_op_p0        <= ds.ds_md_op;
         src1_p0         <= ds.ds_src1;
         src2_p0         <= ds.ds_src2;
         st_data_p0      <= ds.ds_st_data;
         pc_p0           <= ds.ds_pc;
         mem_re_p0       <= ds.ds_mem_re;
         mem_we_p0       <= ds.ds_mem_we;
         mem_unsigned_p0 <= ds.ds_mem_unsigned;
         gr_we_p0        <= ds.ds_gr_we;
         mem_size_p0     <= ds.ds_mem_size;
         dest_p0         <= ds.ds_dest;
      end
   end

   // ALU ops, one-hot: add sub slt sltu and nor or xor sll srl sra lui
   logic [XLEN-1:0] alu_result;
   logic [SHW-1:0]  shamt;
   logic            slt_r, sltu_r;
   assign shamt  = src2_p0[SHW-1:0];
   assign slt_r  = $signed(src1_p0) < $signed(src2_p0);
   assign sltu_r = src1_p0 < src2_p0;

   always_comb begin
      alu_result = '0;
      if (alu_op_p0[0])  alu_result = alu_result | (src1_p0 + src2_p0);
      if (alu_op_p0[1])  alu_result = alu_result | (src1_p0 - src2_p0);
      if (alu_op_p0[2])  alu_result = alu_result | {{(XLEN-1){1'b0}}, slt_r};
      if (alu_op_p0[3])  alu_result = alu_result | {{(XLEN-1){1'b0}}, sltu_r};
      if (alu_op_p0[4])  alu_result = alu_result | (src1_p0 & src2_p0);
      if (alu_op_p0[5])  alu_result = alu_result | ~(src1_p0 | src2_p0);
      if (alu_op_p0[6])  alu_result = alu_result | (src1_p0 | src2_p0);
      if (alu_op_p0[7])  alu_result = alu_result | (src1_p0 ^ src2_p0);
      if (alu_op_p0[8])  alu_result = alu_result | (src1_p0 << shamt);
      if (alu_op_p0[9])  alu_result = alu_result | (src1_p0 >> shamt);
      if (alu_op_p0[10]) alu_result = alu_result | XLEN'($signed(src1_p0) >>> shamt);
      if (alu_op_p0[11]) alu_result = alu_result | src2_p0;
   end

   logic signed [2*XLEN-1:0] mul_a_s, mul_b_s, prod_ss;
   logic        [2*XLEN-1:0] mul_a_u, mul_b_u, prod_uu;
   assign mul_a_s = {{XLEN{src1_p0[XLEN-1]}}, src1_p0};
   assign mul_b_s = {{XLEN{src2_p0[XLEN-1]}}, src2_p0};
   assign mul_a_u = {{XLEN{1'b0}}, src1_p0};
   assign mul_b_u = {{XLEN{1'b0}}, src2_p0};
   assign prod_ss = mul_a_s * mul_b_s;
   assign prod_uu = mul_a_u * mul_b_u;

   logic [XLEN:0] rem_sh, rem_diff;
   assign rem_sh   = {r_acc, q_acc[XLEN-1]};
   assign rem_diff = rem_sh - {1'b0, d_mag};

   // ---- divider: IDLE latches magnitudes, BUSY retires one quotient bit per cycle ----
   always_ff @(posedge clk) begin
      if (reset) begin
         div_state <= IDLE;
         div_cnt   <= '0;
         q_acc     <= '0;
         r_acc     <= '0;
         d_mag     <= '0;
         q_neg     <= 1'b0;
         r_neg     <= 1'b0;
         div_zero  <= 1'b0;
      end else if (flush) begin
         div_state <= IDLE;
         div_cnt   <= '0;
      end else begin
         case (div_state)
            IDLE: if (vld_p0 && div_class) begin
               div_state <= BUSY;
               div_cnt   <= '0;
               q_acc     <= neg_if(src1_p0, div_signed && src1_p0[XLEN-1]);
               d_mag     <= neg_if(src2_p0, div_signed && src2_p0[XLEN-1]);
               r_acc     <= '0;
               q_neg     <= div_signed && (src1_p0[XLEN-1] ^ src2_p0[XLEN-1]);
               r_neg     <= div_signed && src1_p0[XLEN-1];
               div_zero  <= (src2_p0 == '0);
            end
            BUSY: begin
               div_cnt <= div_cnt + CNTW'(1);
               if (!rem_diff[XLEN]) begin
                  r_acc <= rem_diff[XLEN-1:0];
                  q_acc <= {q_acc[XLEN-2:0], 1'b1};
               end else begin
                  r_acc <= rem_sh[XLEN-1:0];
                  q_acc <= {q_acc[XLEN-2:0], 1'b0};
               end
               if (div_cnt == CNTW'(XLEN-1)) div_state <= DONE;
            end
            DONE: if (ms_allowin) div_state <= IDLE;
            default: div_state <= IDLE;
         endcase
      end
   end

   logic [XLEN-1:0] quo_fix, rem_fix, md_result;
   assign quo_fix = div_zero ? '1 : neg_if(q_acc, q_neg);
   assign rem_fix = div_zero ? src1_p0 : neg_if(r_acc, r_neg);

   always_comb begin
      case (md_op_p0)
         3'd1:       md_result = prod_uu[XLEN-1:0];
         3'd2:       md_result = prod_ss[2*XLEN-1:XLEN];
         3'd3:       md_result = prod_uu[2*XLEN-1:XLEN];
         3'd4, 3'd6: md_result = quo_fix;
         3'd5, 3'd7: md_result = rem_fix;
         default:    md_result = '0;
      endcase
   end

   assign es_result = (md_op_p0 != 3'd0) ? md_result : alu_result;

   logic misalign;
   always_comb begin
      case (mem_size_p0)
         2'd1:    misalign = es_result[0];
         2'd2:    misalign = |es_result[1:0];
         2'd3:    misalign = |es_result[2:0];
         default: misalign = 1'b0;
      endcase
   end
   assign es_ale = (mem_re_p0 || mem_we_p0) && misalign;

   logic [NBYTE-1:0] size_mask;
   always_comb begin
      case (mem_size_p0)
         2'd0:    size_mask = NBYTE'(1);
         2'd1:    size_mask = NBYTE'(3);
         2'd2:    size_mask = NBYTE'(15);
         default: size_mask = '1;
      endcase
   end

   always_comb begin
      data_sram_wdata = '0;
      for (int i = 0; i < NBYTE; i++) begin
         case (mem_size_p0)
            2'd0:    data_sram_wdata[8*i +: 8] = st_data_p0[7:0];
            2'd1:    data_sram_wdata[8*i +: 8] = st_data_p0[8*(i%2) +: 8];
            2'd2:    data_sram_wdata[8*i +: 8] = st_data_p0[8*(i%4) +: 8];
            default: data_sram_wdata[8*i +: 8] = st_data_p0[8*i +: 8];
         endcase
      end
   end

   // the request fires only in the cycle the instruction moves on to ms
   assign data_sram_en   = vld_p0 && (mem_re_p0 || mem_we_p0) && !es_ale && ms_allowin && !flush;
   assign data_sram_wen  = mem_we_p0 ? (size_mask << es_result[OFFW-1:0]) : '0;
   assign data_sram_addr = es_result;

   assign es_gr_we        = gr_we_p0;
   assign es_mem_re       = mem_re_p0;
   assign es_mem_unsigned = mem_unsigned_p0;
   assign es_mem_size     = mem_size_p0;
   assign es_dest         = dest_p0;
   assign es_pc           = pc_p0;

   assign es_fwd_valid = vld_p0 && gr_we_p0;
   assign es_fwd_blk   = vld_p0 && (mem_re_p0 || (div_class && !es_ready_go));
   assign es_fwd_dest  = dest_p0;
   assign es_fwd_data  = es_result;

endmodule
